clock_switch_ctrl: RTL

CLOCK_SWITCH_CTRL -- requirements
Module: clock_switch_ctrl

---
 rtl/clock_switch_ctrl.sv | 132 +++++++++++++
 1 files changed

// File: rtl/clock_switch_ctrl.sv
// Glitch-free clock select sequencer: gate, switch, settle, then re-enable.
// Optional completed-switch counter is enabled by defining CLKSW_COUNT_EN.
module clock_switch_ctrl #(
  parameter int unsigned GATE_CYCLES   = 4,
  parameter int unsigned SETTLE_CYCLES = 8,
  parameter logic        RESET_SEL     = 1'b0
) (
  input  logic       clk_i,
  input  logic       reset_n_i,
  input  logic       switch_valid_i,
  input  logic       switch_sel_i,
  output logic       switch_ready_o,
  output logic       sel_o,
  output logic       clk_en_o,
  output logic       busy_o,
  output logic       done_o,
  output logic [7:0] switch_cnt_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GATE   = 2'd1,
    SWITCH = 2'd2,
    SETTLE = 2'd3
  } state_e;

  localparam logic [8:0] GATE_LOAD   = 9'(GATE_CYCLES - 1);
  localparam logic [8:0] SETTLE_LOAD = 9'(SETTLE_CYCLES - 1);

  state_e     state_q, state_d;
  logic [8:0] cnt_q, cnt_d;
  logic       target_q, target_d;
  logic       sel_q, sel_d;
  logic       clk_en_q, clk_en_d;
  logic       done_q, done_d;

  // State, counter and registered output flops
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q  <= IDLE;
      cnt_q    <= 9'd0;
      target_q <= RESET_SEL;
      sel_q    <= RESET_SEL;
      clk_en_q <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      target_q <= target_d;
      sel_q    <= sel_d;
      clk_en_q <= clk_en_d;
      done_q   <= done_d;
    end
  end

  // Next-state and next-output logic; the select only moves on the GATE->SWITCH step
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    target_d = target_q;
    sel_d    = sel_q;
    clk_en_d = clk_en_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (switch_valid_i) begin
          if (switch_sel_i == sel_q) begin
            done_d = 1'b1;
          end else begin
            target_d = switch_sel_i;
            cnt_d    = GATE_LOAD;
            clk_en_d = 1'b0;
            state_d  = GATE;
          end
        end else begin
          state_d = IDLE;
        end
      end
      GATE: begin
        if (cnt_q == 9'd0) begin
          sel_d   = target_q;
          state_d = SWITCH;
        end else begin
          cnt_d = cnt_q - 9'd1;
        end
      end
      SWITCH: begin
        cnt_d   = SETTLE_LOAD;
        state_d = SETTLE;
      end
      SETTLE: begin
        if (cnt_q == 9'd0) begin
          clk_en_d = 1'b1;
          done_d   = 1'b1;
          state_d  = IDLE;
        end else begin
          cnt_d = cnt_q - 9'd1;
        end
      end
      default: begin
        clk_en_d = 1'b1;
        state_d  = IDLE;
      end
    endcase
  end

  assign switch_ready_o = (state_q == IDLE);
  assign busy_o         = (state_q != IDLE);
  assign sel_o          = sel_q;
  assign clk_en_o       = clk_en_q;
  assign done_o         = done_q;

`ifdef CLKSW_COUNT_EN
  logic [7:0] switch_cnt_q;

  // Saturating count of completed real select changes (no-op requests excluded)
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      switch_cnt_q <= 8'd0;
    end else if ((state_q == SETTLE) && (cnt_q == 9'd0) && (switch_cnt_q != 8'd255)) begin
      switch_cnt_q <= switch_cnt_q + 8'd1;
    end else begin
      switch_cnt_q <= switch_cnt_q;
    end
  end

  assign switch_cnt_o = switch_cnt_q;
`else
  assign switch_cnt_o = 8'd0;
`endif

endmodule
